// File: rtl/counter_b.sv
// Memory-B address counter: wraps modulo LAST+1 and flags the terminal address
// and the wrap event. Reset is asynchronous and active-low.
module counter_b #(
  parameter int          WIDTH = 2,
  parameter int unsigned LAST  = 2**WIDTH - 1
) (
  input  logic             IncB,
  input  logic             Reset,
  input  logic             clk,
  output logic [WIDTH-1:0] AddrB,
  output logic             LastB,
  output logic             WrapB
);

  localparam logic [WIDTH-1:0] LAST_ADDR = WIDTH'(LAST);

  logic [WIDTH-1:0] r_addr;
  logic             r_wrap;
  logic [WIDTH-1:0] w_addr_nxt;
  logic             w_wrap_nxt;
  logic             w_at_last;

  assign w_at_last = (r_addr == LAST_ADDR);

  // Next address and wrap flag; an out-of-range address also folds back to 0
  always_comb begin
    w_addr_nxt = r_addr;
    w_wrap_nxt = 1'b0;
    if (IncB) begin
      if (r_addr >= LAST_ADDR) begin
        w_addr_nxt = '0;
        w_wrap_nxt = 1'b1;
      end else begin
        w_addr_nxt = r_addr + WIDTH'(1);
        w_wrap_nxt = 1'b0;
      end
    end else begin
      w_addr_nxt = r_addr;
      w_wrap_nxt = 1'b0;
    end
  end

  // Address and wrap-pulse registers
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_addr <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_addr <= w_addr_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign AddrB = r_addr;
  assign WrapB = r_wrap;
  assign LastB = w_at_last;

endmodule

// File: tb/tb_counter_b.sv
// Directed bench for counter_b: default WIDTH=2, LAST=2, WIDTH=4 and LAST=0
// instances, each driven in its own phase with hand-computed expectations.
module tb_counter_b;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_inc, a_rst, a_last, a_wrap;
  logic [1:0] a_addr;
  logic       b_inc, b_rst, b_last, b_wrap;
  logic [1:0] b_addr;
  logic       c_inc, c_rst, c_last, c_wrap;
  logic [3:0] c_addr;
  logic       d_inc, d_rst, d_last, d_wrap;
  logic [1:0] d_addr;

  counter_b #(.WIDTH(2)) u_a (
    .IncB(a_inc), .Reset(a_rst), .clk(clk),
    .AddrB(a_addr), .LastB(a_last), .WrapB(a_wrap)
  );
  counter_b #(.WIDTH(2), .LAST(2)) u_b (
    .IncB(b_inc), .Reset(b_rst), .clk(clk),
    .AddrB(b_addr), .LastB(b_last), .WrapB(b_wrap)
  );
  counter_b #(.WIDTH(4)) u_c (
    .IncB(c_inc), .Reset(c_rst), .clk(clk),
    .AddrB(c_addr), .LastB(c_last), .WrapB(c_wrap)
  );
  counter_b #(.WIDTH(2), .LAST(0)) u_d (
    .IncB(d_inc), .Reset(d_rst), .clk(clk),
    .AddrB(d_addr), .LastB(d_last), .WrapB(d_wrap)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_a [5];
    int exp_l [5];
    int exp_w [5];
    int wrap_cnt;
    exp_a = '{1, 2, 3, 0, 1};
    exp_l = '{0, 0, 1, 0, 0};
    exp_w = '{0, 0, 0, 1, 0};

    a_inc = 1'b0; b_inc = 1'b0; c_inc = 1'b0; d_inc = 1'b0;
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1; d_rst = 1'b1;
    #2;
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0; d_rst = 1'b0;
    #1;
    check_eq("rst_addr", a_addr, 0);
    check_eq("rst_wrap", a_wrap, 0);
    check_eq("rst_last", a_last, 0);
    check_eq("rst_last0_last", d_last, 1);
    check_eq("rst_last0_addr", d_addr, 0);

    // Reset held with IncB=1 while clk runs
    a_inc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq($sformatf("rst_hold_addr%0d", i), a_addr, 0);
      check_eq($sformatf("rst_hold_wrap%0d", i), a_wrap, 0);
    end

    // Release between edges, then count through a wrap
    a_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq($sformatf("cnt_addr%0d", i), a_addr, 32'(exp_a[i]));
      check_eq($sformatf("cnt_last%0d", i), a_last, 32'(exp_l[i]));
      check_eq($sformatf("cnt_wrap%0d", i), a_wrap, 32'(exp_w[i]));
    end

    // Hold at 2
    step();
    check_eq("pre_hold_addr", a_addr, 2);
    a_inc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("hold_addr%0d", i), a_addr, 2);
      check_eq($sformatf("hold_last%0d", i), a_last, 0);
      check_eq($sformatf("hold_wrap%0d", i), a_wrap, 0);
    end

    // Reset asserted mid-cycle at the terminal address
    a_inc = 1'b1;
    step();
    check_eq("at3_addr", a_addr, 3);
    check_eq("at3_last", a_last, 1);
    #2 a_rst = 1'b0;
    #1;
    check_eq("async_addr", a_addr, 0);
    check_eq("async_last", a_last, 0);
    check_eq("async_wrap", a_wrap, 0);
    step();
    check_eq("async_post_addr", a_addr, 0);
    check_eq("async_post_wrap", a_wrap, 0);
    a_rst = 1'b1;
    step();
    check_eq("rel_inc_addr", a_addr, 1);
    step();
    step();
    step();
    check_eq("rewrap_addr", a_addr, 0);
    check_eq("rewrap_wrap", a_wrap, 1);
    #2 a_rst = 1'b0;
    #1;
    check_eq("rst_kills_wrap", a_wrap, 0);

    // LAST=2: 0,1,2,0,... with wrap every third edge
    b_rst = 1'b1;
    b_inc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq($sformatf("l2_addr%0d", i), b_addr, 32'((i + 1) % 3));
      check_eq($sformatf("l2_last%0d", i), b_last, 32'(((i + 1) % 3) == 2));
      check_eq($sformatf("l2_wrap%0d", i), b_wrap, 32'(((i + 1) % 3) == 0));
    end

    // WIDTH=4 default LAST: 17 edges, exactly one wrap
    c_rst = 1'b1;
    c_inc = 1'b1;
    wrap_cnt = 0;
    for (int k = 1; k <= 17; k++) begin
      step();
      check_eq($sformatf("w4_addr%0d", k), c_addr, 32'(k % 16));
      check_eq($sformatf("w4_last%0d", k), c_last, 32'((k % 16) == 15));
      if (c_wrap === 1'b1) wrap_cnt++;
    end
    check_eq("w4_wrap_count", 32'(wrap_cnt), 1);

    // LAST=0: address pinned at 0, wrap on every increment
    d_rst = 1'b1;
    d_inc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("l0_addr%0d", i), d_addr, 0);
      check_eq($sformatf("l0_wrap%0d", i), d_wrap, 1);
      check_eq($sformatf("l0_last%0d", i), d_last, 1);
    end
    d_inc = 1'b0;
    step();
    check_eq("l0_idle_wrap", d_wrap, 0);
    check_eq("l0_idle_addr", d_addr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_b.md
COUNTER_B -- requirements
Module: counter_b

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, setting the address width in bits.
REQ-002 The block SHALL have parameter LAST, default 2**WIDTH-1, setting the terminal address; legal range 0..2**WIDTH-1.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port IncB  input  1  increment enable, sampled on rising clk.
REQ-006 The block SHALL have port AddrB  output  WIDTH  current memory-B address, registered.
REQ-007 The block SHALL have port LastB  output  1  high while AddrB equals LAST, combinational decode of the AddrB register.
REQ-008 The block SHALL have port WrapB  output  1  registered one-cycle pulse, high in the cycle after AddrB wraps from LAST to 0.
REQ-009 The positional port order SHALL be IncB, Reset, clk, AddrB, LastB, WrapB, so that positional instantiation with the first four ports connects correctly.
REQ-010 The design SHALL use one clock, with reset asynchronous and active-low.

Function
REQ-011 On a rising clk edge with Reset high and IncB high, AddrB SHALL become AddrB+1, or 0 when AddrB equals LAST.
REQ-012 On a rising clk edge with Reset high and IncB low, AddrB SHALL hold its value.
REQ-013 Increment latency SHALL be one clock: the new AddrB is visible after the edge that sampled IncB=1.
REQ-014 Arithmetic SHALL be unsigned modulo LAST+1; AddrB SHALL never exceed LAST.
REQ-015 WrapB SHALL be 1 for exactly one cycle after an edge where IncB=1 and AddrB=LAST, and 0 otherwise.
REQ-016 With IncB held high continuously, AddrB SHALL cycle 0,1,...,LAST,0 with no skipped or repeated values, and WrapB SHALL pulse once per cycle of LAST+1 clocks.
REQ-017 LastB SHALL equal (AddrB==LAST) in every cycle, including during reset.
REQ-018 With LAST=0, AddrB SHALL stay 0, and every edge with IncB=1 SHALL produce a WrapB pulse.
REQ-019 IncB SHALL have no effect while Reset is low.

Reset
REQ-020 When Reset goes low, AddrB SHALL become 0 and WrapB SHALL become 0 immediately, independent of clk.
REQ-021 While Reset is low, AddrB and WrapB SHALL stay 0, and LastB SHALL be 1 only if LAST=0.
REQ-022 Reset deassertion (low to high) SHALL be effective at the next rising clk edge; if IncB=1 at that edge, AddrB SHALL become 1.
REQ-023 A reset asserted mid-count, including at AddrB=LAST, SHALL force AddrB to 0 and SHALL NOT produce a WrapB pulse.
REQ-024 Outputs SHALL have no X or undefined values after the first reset assertion.

Verification
REQ-025 Reset low for 1 cycle, then high, with IncB=1 and WIDTH=2 -> AddrB goes 0,1,2,3,0,1 on consecutive edges; LastB is high only at 3; WrapB is high in the cycle AddrB=0 after 3.
REQ-026 Count to 2, then IncB=0 for 3 cycles -> AddrB holds at 2, and LastB and WrapB stay 0.
REQ-027 At AddrB=3, drive Reset low between clock edges -> AddrB becomes 0 before the next edge, and no WrapB pulse occurs.
REQ-028 Reset low with IncB=1 and clk toggling for 4 cycles -> AddrB stays 0 and WrapB stays 0.
REQ-029 LAST=2 with WIDTH=2 and IncB=1 -> AddrB goes 0,1,2,0, never reaches 3, and WrapB pulses every 3rd cycle.
REQ-030 WIDTH=4 with LAST default and IncB=1 for 17 edges -> AddrB goes 0..15 then wraps to 0, with exactly one WrapB pulse.
